alu_arbiter: RTL and testbench

Shares one `alu` instance among `NUM_REQ` requesters. Each requester presents an operation and two 32-bit operands on a valid/ready request channel. The block grants one request at a time, registers the operands, drives the shared ALU and returns the result with the requester's ID on a single valid/ready response channel. It sits between the issue logic of the requesting units and the ALU datapath.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu.sv | 26 ++
 rtl/alu_arbiter_pick.sv | 55 +++++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU and its requester arbiter: operation codes,
// arbiter FSM states and the operation legality check.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_OPERATION_ADD = 4'd0,
        ALU_OPERATION_SUB = 4'd1,
        ALU_OPERATION_MUL = 4'd2,
        ALU_OPERATION_AND = 4'd3,
        ALU_OPERATION_OR  = 4'd4,
        ALU_OPERATION_XOR = 4'd5,
        ALU_OPERATION_NOT = 4'd6
    } alu_operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arbiter_state_t;

    function automatic logic alu_operation_legal(input logic [3:0] operation);
        case (operation)
            ALU_OPERATION_ADD,
            ALU_OPERATION_SUB,
            ALU_OPERATION_MUL,
            ALU_OPERATION_AND,
            ALU_OPERATION_OR,
            ALU_OPERATION_XOR,
            ALU_OPERATION_NOT: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; all arithmetic wraps modulo 2^32.
// Undefined operation codes produce 0.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  operation,
    input  logic [31:0] operand0,
    input  logic [31:0] operand1,
    output logic [31:0] dest
);

    always_comb begin
        dest = '0;
        case (operation)
            ALU_OPERATION_ADD: dest = operand0 + operand1;
            ALU_OPERATION_SUB: dest = operand0 - operand1;
            ALU_OPERATION_MUL: dest = operand0 * operand1;
            ALU_OPERATION_AND: dest = operand0 & operand1;
            ALU_OPERATION_OR:  dest = operand0 | operand1;
            ALU_OPERATION_XOR: dest = operand0 ^ operand1;
            ALU_OPERATION_NOT: dest = ~operand0;
            default:           dest = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_pick.sv
// Combinational winner selection for alu_arbiter. With
// ALU_ARBITER_ROUND_ROBIN_EN defined the search starts after last_grant;
// otherwise the lowest valid index wins.
module alu_arbiter_pick #(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_valid,
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    input  logic [ID_WIDTH-1:0] last_grant,
`endif
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] winner
);

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    // One extra bit so last_grant + offset cannot overflow before the wrap.
    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        winner = '0;
        sum    = '0;
        idx    = '0;
        // Walk offsets from farthest to nearest so the nearest valid wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, last_grant} + (ID_WIDTH + 1)'(k);
            if (sum >= (ID_WIDTH + 1)'(NUM_REQ)) begin
                sum = sum - (ID_WIDTH + 1)'(NUM_REQ);
            end
            idx = sum[ID_WIDTH-1:0];
            if (req_valid[idx]) begin
                winner = idx;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                winner = ID_WIDTH'(k);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (|req_valid) begin
            grant = NUM_REQ'(1) << winner;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: grant, register operands,
// execute, return the tagged result. Arbitration mode: ALU_ARBITER_ROUND_ROBIN_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][3:0]  req_operation,
    input  logic [NUM_REQ-1:0][31:0] req_operand0,
    input  logic [NUM_REQ-1:0][31:0] req_operand1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_WIDTH-1:0]      rsp_id,
    output logic [31:0]              rsp_dest,
    output logic                     rsp_illegal,
    output logic [1:0]               fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // req_ready is a combinational function of req_valid and state; the
    // response holds stable in RESP until rsp_ready is seen high.

    alu_arbiter_state_t state_q;
    alu_arbiter_state_t state_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] winner;
    logic                accept_window;
    logic                accept;
    logic                capture;
    logic                release_rsp;

    logic [3:0]          operation_q;
    logic [31:0]         operand0_q;
    logic [31:0]         operand1_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         alu_dest;
    logic                operation_legal;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] last_grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
        end else if (accept) begin
            last_grant <= winner;
        end
    end

    alu_arbiter_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (winner)
    );
`else
    alu_arbiter_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_valid (req_valid),
        .grant     (grant),
        .winner    (winner)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (rsp_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept_window = 1'b0;
        capture       = 1'b0;
        release_rsp   = 1'b0;
        case (state_q)
            IDLE: accept_window = 1'b1;
            EXEC: capture = 1'b1;
            RESP: begin
                accept_window = rsp_ready;
                release_rsp   = rsp_ready;
            end
            default: accept_window = 1'b0;
        endcase
        // Gated by reset so no requester sees a grant while reset is held.
        req_ready = (reset_n && accept_window) ? grant : '0;
        accept    = |(req_valid & req_ready);
    end

    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operation_q <= '0;
            operand0_q  <= '0;
            operand1_q  <= '0;
            id_q        <= '0;
        end else if (accept) begin
            operation_q <= req_operation[winner];
            operand0_q  <= req_operand0[winner];
            operand1_q  <= req_operand1[winner];
            id_q        <= winner;
        end
    end

    alu u_alu (
        .operation (operation_q),
        .operand0  (operand0_q),
        .operand1  (operand1_q),
        .dest      (alu_dest)
    );

    assign operation_legal = alu_operation_legal(operation_q);

    // The response has its own registers so a back-to-back acceptance in
    // RESP can overwrite id_q without disturbing the outgoing response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_dest    <= '0;
            rsp_illegal <= 1'b0;
        end else if (capture) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= id_q;
            rsp_dest    <= operation_legal ? alu_dest : 32'h0;
            rsp_illegal <= ~operation_legal;
        end else if (release_rsp) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a reference model.
// Arbitration expectations follow ALU_ARBITER_ROUND_ROBIN_EN.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0][3:0]  req_operation;
    logic [NR-1:0][31:0] req_operand0;
    logic [NR-1:0][31:0] req_operand1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [31:0]      rsp_dest;
    logic             rsp_illegal;
    logic [1:0]       fsm_state;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];

    alu_arbiter #(.NUM_REQ(NR)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operation (req_operation),
        .req_operand0  (req_operand0),
        .req_operand1  (req_operand1),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_dest      (rsp_dest),
        .rsp_illegal   (rsp_illegal),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {illegal, result} straight from the operation definitions.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            ALU_OPERATION_ADD: return {1'b0, a + b};
            ALU_OPERATION_SUB: return {1'b0, a - b};
            ALU_OPERATION_MUL: return {1'b0, p[31:0]};
            ALU_OPERATION_AND: return {1'b0, a & b};
            ALU_OPERATION_OR:  return {1'b0, a | b};
            ALU_OPERATION_XOR: return {1'b0, a ^ b};
            ALU_OPERATION_NOT: return {1'b0, ~a};
            default:           return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic int pick(input logic [NR-1:0] v, input int last);
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
`else
        for (int k = 0; k < NR; k++) begin
            if (v[k]) return k;
        end
`endif
        return 0;
    endfunction

    task automatic do_op(input logic [1:0] idx, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         output logic [31:0] got_dest, output logic got_ill);
        logic [32:0] exp;
        logic [63:0] snap;
        int n;
        @(posedge clk); #1;
        req_valid = NR'(1) << idx;
        req_operation[idx] = op;
        req_operand0[idx]  = a;
        req_operand1[idx]  = b;
        rsp_ready = (hold == 0);
        exp = ref_alu(op, a, b);
        n = 0;
        @(negedge clk);
        while (req_ready[idx] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 20), 64'(1));
        check("grant_onehot", 64'(req_ready), 64'(1) << idx);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("exec_rsp_low", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("rsp_latency", 64'(rsp_valid), 64'(1));
        check("rsp_id", 64'(rsp_id), 64'(idx));
        check("rsp_dest", 64'(rsp_dest), 64'(exp[31:0]));
        check("rsp_illegal", 64'(rsp_illegal), 64'(exp[32]));
        got_dest = rsp_dest;
        got_ill  = rsp_illegal;
        snap = 64'({rsp_valid, rsp_illegal, rsp_id, rsp_dest});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_stable", 64'({rsp_valid, rsp_illegal, rsp_id, rsp_dest}), snap);
            check("hold_no_grant", 64'(req_ready), 64'(0));
        end
        if (hold > 0) begin
            @(posedge clk); #1 rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("rsp_released", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] d;
        logic        il;
        logic [63:0] held;
        logic [36:0] e;
        int          order[6];
        int          exp_order[6];
        int          ng;
        int          model_last;
        int          p;

        // Reset values, with every requester asking.
        reset_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_operation = '0;
        req_operand0 = '0;
        req_operand1 = '0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
        check("reset_rsp_dest", 64'(rsp_dest), 64'(0));
        check("reset_rsp_illegal", 64'(rsp_illegal), 64'(0));
        check("reset_state", 64'(fsm_state), 64'(IDLE));
        req_valid = '0;
        reset_n = 1'b1;

        // Contention: all four requesting, responses always accepted.
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0, 1};
`else
        exp_order = '{0, 0, 0, 1, 1, 1};
`endif
        model_last = NR - 1;
        ng = 0;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            req_operation[i] = ALU_OPERATION_ADD;
            req_operand0[i]  = 32'(100 * (i + 1));
            req_operand1[i]  = 32'(i + 3);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && (ng < 6 || exp_q.size() > 0); c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("contention_unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("contention_rsp", 64'({rsp_illegal, 2'b00, rsp_id, rsp_dest}), 64'(e));
                end
            end
            if (|req_ready) begin
                p = pick(req_valid, model_last);
                check("contention_grant", 64'(req_ready), 64'(1) << p);
                if (ng < 6) order[ng] = p;
                ng++;
                model_last = p;
                e[36] = 1'b0;
                e[35:32] = 4'(p);
                e[31:0] = 32'(100 * (p + 1)) + 32'(p + 3);
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            if (ng >= 6) req_valid = '0;
`ifndef ALU_ARBITER_ROUND_ROBIN_EN
            if (ng >= 3) req_valid[0] = 1'b0;
`endif
        end
        check("contention_grants", 64'(ng), 64'(6));
        check("contention_drained", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < 6; i++) begin
            check("contention_order", 64'(order[i]), 64'(exp_order[i]));
        end

        // Single requester ADD.
        do_op(2'd0, ALU_OPERATION_ADD, 32'd5, 32'd7, 0, d, il);
        check("add_5_7", 64'(d), 64'(12));
        check("add_legal", 64'(il), 64'(0));

        // Backpressure with requester 1 waiting behind requester 0.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_operation[0] = ALU_OPERATION_ADD;
        req_operand0[0] = 32'd1;
        req_operand1[0] = 32'd2;
        req_valid = 4'b0001;
        @(negedge clk);
        check("bp_grant0", 64'(req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        req_operation[1] = ALU_OPERATION_SUB;
        req_operand0[1] = 32'd50;
        req_operand1[1] = 32'd8;
        req_valid = 4'b0010;
        @(negedge clk);
        check("bp_exec_no_grant", 64'(req_ready), 64'(0));
        @(negedge clk);
        check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        check("bp_rsp_dest", 64'(rsp_dest), 64'(3));
        held = 64'({rsp_valid, rsp_illegal, rsp_id, rsp_dest});
        repeat (4) begin
            @(negedge clk);
            check("bp_hold", 64'({rsp_valid, rsp_illegal, rsp_id, rsp_dest}), held);
            check("bp_no_grant", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_grant1_on_release", 64'(req_ready), 64'(4'b0010));
        check("bp_rsp_still_valid", 64'(rsp_valid), 64'(1));
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("bp_exec1_rsp_low", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check("bp_rsp1", 64'({rsp_valid, rsp_illegal, rsp_id, rsp_dest}),
              64'({1'b1, 1'b0, 2'd1, 32'd42}));
        @(posedge clk);
        @(negedge clk);
        check("bp_idle", 64'(rsp_valid), 64'(0));

        // Arithmetic edges and an undefined opcode.
        do_op(2'd3, ALU_OPERATION_SUB, 32'd3, 32'd5, 0, d, il);
        check("sub_wrap", 64'(d), 64'(32'hFFFF_FFFE));
        do_op(2'd1, ALU_OPERATION_MUL, 32'h0001_0000, 32'h0001_0000, 1, d, il);
        check("mul_low32", 64'(d), 64'(0));
        do_op(2'd2, ALU_OPERATION_NOT, 32'h0000_FFFF, 32'h1234_5678, 0, d, il);
        check("not_ignores_b", 64'(d), 64'(32'hFFFF_0000));
        do_op(2'd2, 4'hC, 32'hDEAD_BEEF, 32'h1, 2, d, il);
        check("illegal_dest", 64'(d), 64'(0));
        check("illegal_flag", 64'(il), 64'(1));

        // Reset while in EXEC discards the operation.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_operation[2] = ALU_OPERATION_XOR;
        req_operand0[2] = 32'hFF;
        req_operand1[2] = 32'h0F;
        req_valid = 4'b0100;
        @(negedge clk);
        check("rst_grant2", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("rst_in_exec", 64'(fsm_state), 64'(EXEC));
        #1 reset_n = 1'b0;
        req_valid = '1;
        #1;
        check("rst_async_outputs", 64'({req_ready, rsp_valid, rsp_illegal, rsp_id, rsp_dest}), 64'(0));
        check("rst_async_state", 64'(fsm_state), 64'(IDLE));
        repeat (2) @(negedge clk);
        req_valid = '0;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk); #1 req_valid = '1;
        @(negedge clk);
        check("rst_first_grant", 64'(req_ready), 64'(4'b0001));
        @(posedge clk); #1 req_valid = '0;
        repeat (2) @(negedge clk);
        check("rst_rsp_id0", 64'({rsp_valid, rsp_id}), 64'({1'b1, 2'd0}));
        @(posedge clk);
        @(negedge clk);

        // Randomized single-requester operations, some undefined opcodes.
        for (int i = 0; i < 16; i++) begin
            do_op(2'($urandom_range(0, NR - 1)), 4'($urandom_range(0, 9)),
                  32'($urandom), 32'($urandom), int'($urandom_range(0, 2)), d, il);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
